mode_counter_n: RTL and testbench

Parametrised, mode-controlled up/down counter: the next generation of the lab 4-bit mode counter. Adds generic width, a runtime modulus (Limit), saturating modes, an enable, a synchronous clear mode, a terminal-count output, a wrap strobe and a sticky overflow flag. Used as a general counting and timing primitive in the lab datapaths and their self-checking benches.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_next.sv | 82 ++++++++
 rtl/mode_counter_n.sv | 82 ++++++++
 tb/tb_mode_counter_n.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - mode encodings shared by the mode counter and its next-state logic
package counter_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_UP    = 3'b001;
  localparam logic [MODE_W-1:0] MODE_DOWN  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_UPSAT = 3'b100;
  localparam logic [MODE_W-1:0] MODE_DNSAT = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b110;

endpackage

// File: rtl/counter_next.sv
// rtl/counter_next.sv - combinational next count, wrap and saturate decode for mode_counter_n
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  out_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  din_i,
  input  logic [WIDTH-1:0]  limit_i,
  output logic [WIDTH-1:0]  next_o,
  output logic              wrap_o,
  output logic              sat_o
);

  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic             below;
  logic             above;
  logic             at_zero;

  assign inc     = out_i + WIDTH'(1);
  assign dec     = out_i - WIDTH'(1);
  assign below   = (out_i < limit_i);
  assign above   = (out_i > limit_i);
  assign at_zero = (out_i == '0);

  always_comb begin
    next_o = out_i;
    wrap_o = 1'b0;
    sat_o  = 1'b0;
    case (mode_i)
      MODE_UP: begin
        if (below) begin
          next_o = inc;
        end else begin
          next_o = '0;
          wrap_o = 1'b1;
        end
      end
      MODE_DOWN: begin
        // An out-of-range count (Limit lowered) snaps to Limit without a wrap.
        if (at_zero) begin
          next_o = limit_i;
          wrap_o = 1'b1;
        end else if (above) begin
          next_o = limit_i;
        end else begin
          next_o = dec;
        end
      end
      MODE_LOAD: begin
        next_o = (din_i > limit_i) ? limit_i : din_i;
      end
      MODE_UPSAT: begin
        if (below) begin
          next_o = inc;
        end else begin
          next_o = limit_i;
          sat_o  = 1'b1;
        end
      end
      MODE_DNSAT: begin
        if (above) begin
          next_o = limit_i;
        end else if (at_zero) begin
          next_o = '0;
          sat_o  = 1'b1;
        end else begin
          next_o = dec;
        end
      end
      MODE_CLEAR: begin
        next_o = '0;
      end
      default: begin
        next_o = out_i;
      end
    endcase
  end

endmodule

// File: rtl/mode_counter_n.sv
// rtl/mode_counter_n.sv - mode-controlled up/down counter with runtime limit, wrap, saturate and sticky overflow
module mode_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              Ck,
  input  logic              Reset,
  input  logic              En,
  input  logic [MODE_W-1:0] Mode,
  input  logic [WIDTH-1:0]  Din,
  input  logic [WIDTH-1:0]  Limit,
  output logic [WIDTH-1:0]  Out,
  output logic              Tc,
  output logic              Wrap,
  output logic              Sat,
  output logic              Ovf
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_out;
  logic             step_wrap;
  logic             step_sat;

  counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .out_i  (out_q),
    .mode_i (Mode),
    .din_i  (Din),
    .limit_i(Limit),
    .next_o (step_out),
    .wrap_o (step_wrap),
    .sat_o  (step_sat)
  );

  // Disabled edges hold count, Sat and Ovf; Wrap is a pulse so it drops.
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    ovf_d  = ovf_q;
    if (En) begin
      out_d  = step_out;
      wrap_d = step_wrap;
      sat_d  = step_sat;
      ovf_d  = (Mode == MODE_CLEAR) ? 1'b0 : (ovf_q | step_wrap);
    end
  end

  always_ff @(posedge Ck) begin
    if (!Reset) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    Tc = 1'b0;
    if ((Mode == MODE_UP) || (Mode == MODE_UPSAT)) begin
      Tc = (out_q == Limit);
    end else if ((Mode == MODE_DOWN) || (Mode == MODE_DNSAT)) begin
      Tc = (out_q == '0);
    end
  end

  assign Out  = out_q;
  assign Wrap = wrap_q;
  assign Sat  = sat_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_mode_counter_n.sv
// tb/tb_mode_counter_n.sv - directed vector bench for mode_counter_n at WIDTH=4
module tb_mode_counter_n;
  import counter_pkg::*;

  localparam int W = 4;

  logic         Ck;
  logic         Reset;
  logic         En;
  logic [2:0]   Mode;
  logic [W-1:0] Din;
  logic [W-1:0] Limit;
  logic [W-1:0] Out;
  logic         Tc;
  logic         Wrap;
  logic         Sat;
  logic         Ovf;

  int total;
  int bad;

  typedef struct {
    logic         rst_n;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] din;
    logic [W-1:0] limit;
    logic [W-1:0] e_out;
    logic         e_wrap;
    logic         e_sat;
    logic         e_ovf;
    logic         e_tc;
  } vec_t;

  vec_t vecs[$];

  mode_counter_n #(.WIDTH(W)) dut (
    .Ck   (Ck),
    .Reset(Reset),
    .En   (En),
    .Mode (Mode),
    .Din  (Din),
    .Limit(Limit),
    .Out  (Out),
    .Tc   (Tc),
    .Wrap (Wrap),
    .Sat  (Sat),
    .Ovf  (Ovf)
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic r, input logic e, input logic [2:0] m, input logic [W-1:0] d,
                     input logic [W-1:0] l, input logic [W-1:0] o, input logic w, input logic s,
                     input logic ov, input logic t);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.din = d; v.limit = l;
    v.e_out = o; v.e_wrap = w; v.e_sat = s; v.e_ovf = ov; v.e_tc = t;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step %0d: act=%0d req=%0d", name, idx, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge Ck);
    Reset = v.rst_n; En = v.en; Mode = v.mode; Din = v.din; Limit = v.limit;
    @(posedge Ck);
    #1;
    chk("out", idx, Out, v.e_out);
    chk("wrap", idx, W'(Wrap), W'(v.e_wrap));
    chk("sat", idx, W'(Sat), W'(v.e_sat));
    chk("ovf", idx, W'(Ovf), W'(v.e_ovf));
    chk("tc", idx, W'(Tc), W'(v.e_tc));
  endtask

  initial begin
    vec_t h;
    total = 0;
    bad   = 0;
    Reset = 1'b0; En = 1'b0; Mode = MODE_HOLD; Din = '0; Limit = '0;

    //  rst en mode        din lim  out w s o tc
    add(0, 0, MODE_HOLD,   0,  9,   0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++)
      add(1, 1, MODE_UP, 0, 9, W'(i), 0, 0, 0, (i == 9));
    add(1, 1, MODE_UP,     0,  9,   0, 1, 0, 1, 0);
    add(1, 1, MODE_UP,     0,  9,   1, 0, 0, 1, 0);
    add(1, 1, MODE_UP,     0,  9,   2, 0, 0, 1, 0);
    add(1, 1, MODE_CLEAR,  0, 15,   0, 0, 0, 0, 0);
    add(1, 1, MODE_DOWN,   0, 15,  15, 1, 0, 1, 0);
    add(1, 1, MODE_CLEAR,  0, 15,   0, 0, 0, 0, 0);
    add(1, 1, MODE_LOAD,  12,  5,   5, 0, 0, 0, 0);
    add(1, 1, MODE_UPSAT,  0,  5,   5, 0, 1, 0, 1);
    add(1, 1, MODE_UPSAT,  0,  5,   5, 0, 1, 0, 1);
    add(1, 1, MODE_DNSAT,  0,  5,   4, 0, 0, 0, 0);
    add(1, 1, MODE_LOAD,   8, 15,   8, 0, 0, 0, 0);
    add(1, 1, MODE_UP,     0,  3,   0, 1, 0, 1, 0);
    add(1, 1, MODE_LOAD,   8, 15,   8, 0, 0, 1, 0);
    add(1, 1, MODE_DOWN,   0,  3,   3, 0, 0, 1, 0);
    add(1, 1, MODE_UP,     0,  0,   0, 1, 0, 1, 1);
    add(1, 1, MODE_UP,     0,  0,   0, 1, 0, 1, 1);
    add(1, 1, MODE_DOWN,   0,  0,   0, 1, 0, 1, 1);
    add(1, 1, MODE_UPSAT,  0,  0,   0, 0, 1, 1, 1);
    add(1, 1, MODE_DNSAT,  0,  0,   0, 0, 1, 1, 1);
    add(1, 1, 3'b111,      0,  0,   0, 0, 0, 1, 0);
    add(1, 1, MODE_LOAD,  12, 15,  12, 0, 0, 1, 0);
    add(1, 1, MODE_DNSAT,  0,  7,   7, 0, 0, 1, 0);
    add(1, 1, MODE_DOWN,   0,  7,   6, 0, 0, 1, 0);
    add(1, 1, MODE_UP,     0,  7,   7, 0, 0, 1, 1);
    add(1, 1, MODE_HOLD,   3,  7,   7, 0, 0, 1, 0);
    add(1, 1, MODE_LOAD,   3,  7,   3, 0, 0, 1, 0);
    add(1, 1, MODE_DNSAT,  0,  7,   2, 0, 0, 1, 0);
    add(1, 1, MODE_DNSAT,  0,  7,   1, 0, 0, 1, 0);
    add(1, 1, MODE_DNSAT,  0,  7,   0, 0, 0, 1, 1);
    add(1, 1, MODE_DNSAT,  0,  7,   0, 0, 1, 1, 1);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Enable gating: Sat must hold while disabled, Wrap must drop.
    h.rst_n = 1; h.en = 1; h.mode = MODE_LOAD; h.din = 7; h.limit = 7;
    h.e_out = 7; h.e_wrap = 0; h.e_sat = 0; h.e_ovf = 1; h.e_tc = 0;
    apply(h, 100);
    h.mode = MODE_UPSAT; h.e_sat = 1; h.e_tc = 1;
    apply(h, 101);
    h.en = 0; h.mode = MODE_UP; h.limit = 9; h.e_tc = 0;
    for (int i = 0; i < 2; i++) apply(h, 102 + i);
    h.en = 1; h.limit = 7; h.e_out = 0; h.e_wrap = 1; h.e_sat = 0;
    apply(h, 110);
    h.en = 0; h.e_wrap = 0;
    for (int i = 0; i < 5; i++) apply(h, 111 + i);

    // Reset while disabled, then resume counting from zero.
    h.en = 1; h.limit = 9; h.e_out = 1;
    apply(h, 120);
    h.e_out = 2;
    apply(h, 121);
    h.rst_n = 0; h.en = 0; h.e_out = 0; h.e_ovf = 0;
    apply(h, 122);
    h.rst_n = 1; h.en = 1; h.e_out = 1;
    apply(h, 123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
